mem_bus_arbiter: RTL and testbench

- Shares one external memory bus between the instruction-fetch port (IF) and the data port (MEM).
- Sits beside the pipeline; raises per-stage stall requests into ctrl while an access is pending.
- Data port has fixed priority: MEM holds the older instruction, and the pipeline cannot drain past it.
- Bus is a variable-latency req/ack handshake; the arbiter registers and holds all bus outputs for the whole transaction.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 64 ++++++
 rtl/mem_bus_arbiter_watchdog.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter slice.
// Contents:
//   INST_ADDR_WIDTH / REG_DATA_WIDTH - default address and data widths
//   SEL_WORD                         - byte-enable pattern used for fetches
//   arb_state_e                      - arbiter FSM state encoding
package mem_bus_arbiter_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH  = 32;

  localparam logic [3:0] SEL_WORD = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Groups the pipeline-side request ports (IF and MEM), the external memory
// bus and the stall/error outputs of the arbiter.
// Modports:
//   master - the arbiter's view: it receives pipeline requests and drives
//            the external memory bus
//   slave  - the environment's view: pipeline stages plus the memory device
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int DATA_W = REG_DATA_WIDTH
);

  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data port
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_sel;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // External memory bus
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  // Status towards the pipeline controller
  logic              stall_req_if;
  logic              stall_req_mem;
  logic              bus_err;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack,
    output stall_req_if, stall_req_mem, bus_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_rdata, bus_ack,
    input  stall_req_if, stall_req_mem, bus_err
  );

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog
// Bus wait-time watchdog for the memory bus arbiter. Only compiled when
// ARB_TIMEOUT_EN is defined, since nothing else instantiates it.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   busy_i    - arbiter currently owns an outstanding bus transaction
//   expired_o - this busy cycle is the TIMEOUT_CYCLES-th one of the
//               current transaction
`ifdef ARB_TIMEOUT_EN
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counts the busy cycles already completed for the current transaction.
  // Idle cycles hold it at zero, so every grant starts a fresh count. The
  // counter saturates so an unusually long stall cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The current cycle completes the limit when the count would reach it.
  assign expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external variable-latency memory bus between the instruction
// fetch port (IF) and the data port (MEM). MEM has fixed priority because it
// holds the older instruction. All bus outputs are registered and held for
// the whole transaction; completion is returned as a one-cycle ack with the
// read data registered alongside it.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus_if - mem_bus_arbiter_if.master: IF/MEM request ports, external bus,
//            stall requests and bus_err
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   - a watchdog aborts a transaction after TIMEOUT_CYCLES busy
//               cycles without bus_ack; the owner gets an ack with zero data
//               and bus_err pulses in the same cycle
//   undefined - transactions wait indefinitely and bus_err is tied low
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = INST_ADDR_WIDTH,
  parameter int DATA_W         = REG_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_arbiter_if.master    bus_if
);

  arb_state_e        state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [3:0]        bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_ack_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              dm_ack_q;
  logic              bus_err_q;
  logic              timeoutHit;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_i    (state_q != ARB_IDLE),
    .expired_o (timeoutHit)
  );
`else
  logic unusedTimeoutParam;
  assign unusedTimeoutParam = |TIMEOUT_CYCLES;
  assign timeoutHit         = 1'b0;
`endif

  // Arbiter FSM. Acks and bus_err are single-cycle pulses, so they default
  // low every cycle. A requester whose ack is currently high is not sampled
  // in IDLE: its stage is still stalled and re-presenting the same request,
  // and granting it again would issue the access twice. A bus_ack that
  // arrives while no transaction is outstanding is ignored because IDLE
  // never looks at it. A timeout returns zero data; a bus_ack in the same
  // cycle wins and completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_rdata_q  <= '0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (bus_if.dm_req && !dm_ack_q) begin
            state_q     <= ARB_DM_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= bus_if.dm_we;
            bus_sel_q   <= bus_if.dm_sel;
            bus_addr_q  <= bus_if.dm_addr;
            bus_wdata_q <= bus_if.dm_wdata;
          end else if (bus_if.if_req && !if_ack_q) begin
            state_q     <= ARB_IF_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= SEL_WORD;
            bus_addr_q  <= bus_if.if_addr;
            bus_wdata_q <= '0;
          end
        end
        ARB_DM_BUSY: begin
          if (bus_if.bus_ack) begin
            state_q    <= ARB_IDLE;
            bus_req_q  <= 1'b0;
            dm_ack_q   <= 1'b1;
            dm_rdata_q <= bus_we_q ? '0 : bus_if.bus_rdata;
          end else if (timeoutHit) begin
            state_q    <= ARB_IDLE;
            bus_req_q  <= 1'b0;
            dm_ack_q   <= 1'b1;
            dm_rdata_q <= '0;
            bus_err_q  <= 1'b1;
          end
        end
        ARB_IF_BUSY: begin
          if (bus_if.bus_ack) begin
            state_q    <= ARB_IDLE;
            bus_req_q  <= 1'b0;
            if_ack_q   <= 1'b1;
            if_rdata_q <= bus_if.bus_rdata;
          end else if (timeoutHit) begin
            state_q    <= ARB_IDLE;
            bus_req_q  <= 1'b0;
            if_ack_q   <= 1'b1;
            if_rdata_q <= '0;
            bus_err_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.bus_req   = bus_req_q;
  assign bus_if.bus_we    = bus_we_q;
  assign bus_if.bus_sel   = bus_sel_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.if_rdata  = if_rdata_q;
  assign bus_if.if_ack    = if_ack_q;
  assign bus_if.dm_rdata  = dm_rdata_q;
  assign bus_if.dm_ack    = dm_ack_q;
  assign bus_if.bus_err   = bus_err_q;

  // Stall requests follow the live request and the registered ack so that a
  // stage is released in exactly the cycle its ack is presented.
  assign bus_if.stall_req_if  = bus_if.if_req & ~if_ack_q;
  assign bus_if.stall_req_mem = bus_if.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter. Expected completions are
// queued when a request is driven and retired by a monitor when an ack
// appears. With ARB_TIMEOUT_EN defined the DUT is built with a four-cycle
// watchdog and the timeout scenarios are exercised as well.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int TimeoutCycles = 4;
`else
  localparam int TimeoutCycles = 255;
`endif

  typedef struct {
    logic        isData;
    logic [31:0] rdata;
  } expect_t;

  logic    clk;
  logic    rst_n;
  int      checks;
  int      errors;
  int      grantCount;
  logic    prevBusReq;
  expect_t sb[$];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

  mem_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (busIf)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed no end of test, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  // One comparison: counts it, and on mismatch counts the error and reports
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives both pipeline request ports in one go
  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dmReq, input logic dmWe,
                               input logic [3:0] dmSel, input logic [31:0] dmAddr,
                               input logic [31:0] dmWdata);
    busIf.if_req   = ifReq;
    busIf.if_addr  = ifAddr;
    busIf.dm_req   = dmReq;
    busIf.dm_we    = dmWe;
    busIf.dm_sel   = dmSel;
    busIf.dm_addr  = dmAddr;
    busIf.dm_wdata = dmWdata;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation,
  // and rising edges of bus_req are counted as bus transactions issued
  always @(negedge clk) begin
    expect_t e;
    if (busIf.if_ack === 1'b1 || busIf.dm_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedAck", {62'd0, busIf.if_ack, busIf.dm_ack}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ackOwnerIsData", {63'd0, busIf.dm_ack}, {63'd0, e.isData});
        checkOutput("ackRdata", {32'd0, e.isData ? busIf.dm_rdata : busIf.if_rdata},
                    {32'd0, e.rdata});
      end
    end
    if (busIf.bus_req === 1'b1 && prevBusReq !== 1'b1) grantCount++;
    prevBusReq = busIf.bus_req;
  end

  initial begin
    int grantsBefore;
    checks     = 0;
    errors     = 0;
    grantCount = 0;
    prevBusReq = 1'b0;
    rst_n      = 1'b0;
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rstBusReq", {63'd0, busIf.bus_req}, 64'd0);
    checkOutput("rstIfAck", {63'd0, busIf.if_ack}, 64'd0);
    checkOutput("rstDmAck", {63'd0, busIf.dm_ack}, 64'd0);
    checkOutput("rstBusErr", {63'd0, busIf.bus_err}, 64'd0);
    checkOutput("rstIfRdata", {32'd0, busIf.if_rdata}, 64'd0);
    checkOutput("rstBusAddr", {32'd0, busIf.bus_addr}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch with bus_ack three cycles after bus_req
    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sb.push_back('{isData: 1'b0, rdata: 32'h3401_1234});
    #1;
    checkOutput("fetchStallHigh", {63'd0, busIf.stall_req_if}, 64'd1);
    tick();
    checkOutput("fetchBusReq", {63'd0, busIf.bus_req}, 64'd1);
    checkOutput("fetchBusSel", {60'd0, busIf.bus_sel}, {60'd0, SEL_WORD});
    checkOutput("fetchBusWe", {63'd0, busIf.bus_we}, 64'd0);
    checkOutput("fetchBusAddr", {32'd0, busIf.bus_addr}, 64'h10);
    checkOutput("fetchBusWdata", {32'd0, busIf.bus_wdata}, 64'd0);
    tick();
    tick();
    tick();
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'h3401_1234;
    #1;
    checkOutput("fetchStallWait", {63'd0, busIf.stall_req_if}, 64'd1);
    checkOutput("fetchNoEarlyAck", {63'd0, busIf.if_ack}, 64'd0);
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    checkOutput("fetchAck", {63'd0, busIf.if_ack}, 64'd1);
    checkOutput("fetchRdata", {32'd0, busIf.if_rdata}, 64'h3401_1234);
    checkOutput("fetchBusReqDrop", {63'd0, busIf.bus_req}, 64'd0);
    checkOutput("fetchStallLow", {63'd0, busIf.stall_req_if}, 64'd0);
    checkOutput("fetchBusErr", {63'd0, busIf.bus_err}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    checkOutput("fetchAckPulse", {63'd0, busIf.if_ack}, 64'd0);

    // Simultaneous requests: the store is granted first
    $display("[TB] simultaneous fetch and store");
    applyStimulus(1'b1, 32'h0000_0020, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
    sb.push_back('{isData: 1'b1, rdata: 32'h0});
    sb.push_back('{isData: 1'b0, rdata: 32'h1111_2222});
    tick();
    checkOutput("simStoreBusReq", {63'd0, busIf.bus_req}, 64'd1);
    checkOutput("simStoreWe", {63'd0, busIf.bus_we}, 64'd1);
    checkOutput("simStoreSel", {60'd0, busIf.bus_sel}, 64'h3);
    checkOutput("simStoreAddr", {32'd0, busIf.bus_addr}, 64'h100);
    checkOutput("simStoreWdata", {32'd0, busIf.bus_wdata}, 64'hDEAD_BEEF);
    checkOutput("simFetchStall", {63'd0, busIf.stall_req_if}, 64'd1);
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'hAAAA_5555;
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    checkOutput("simStoreAck", {63'd0, busIf.dm_ack}, 64'd1);
    checkOutput("simStoreRdataZero", {32'd0, busIf.dm_rdata}, 64'd0);
    checkOutput("simGapBusReq", {63'd0, busIf.bus_req}, 64'd0);
    busIf.dm_req = 1'b0;
    tick();
    checkOutput("simFetchBusReq", {63'd0, busIf.bus_req}, 64'd1);
    checkOutput("simFetchAddr", {32'd0, busIf.bus_addr}, 64'h20);
    checkOutput("simFetchSel", {60'd0, busIf.bus_sel}, 64'hF);
    checkOutput("simFetchWe", {63'd0, busIf.bus_we}, 64'd0);
    checkOutput("simFetchWdata", {32'd0, busIf.bus_wdata}, 64'd0);
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'h1111_2222;
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    checkOutput("simFetchAck", {63'd0, busIf.if_ack}, 64'd1);
    busIf.if_req = 1'b0;
    tick();
    checkOutput("simIdleBusReq", {63'd0, busIf.bus_req}, 64'd0);

    // Load request held through its ack cycle and one more cycle
    $display("[TB] held request");
    grantsBefore = grantCount;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    sb.push_back('{isData: 1'b1, rdata: 32'hCAFE_0001});
    tick();
    checkOutput("heldBusReq", {63'd0, busIf.bus_req}, 64'd1);
    checkOutput("heldBusWe", {63'd0, busIf.bus_we}, 64'd0);
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'hCAFE_0001;
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    checkOutput("heldAck", {63'd0, busIf.dm_ack}, 64'd1);
    checkOutput("heldStallLow", {63'd0, busIf.stall_req_mem}, 64'd0);
    tick();
    checkOutput("heldNoRegrant", {63'd0, busIf.bus_req}, 64'd0);
    checkOutput("heldAckPulse", {63'd0, busIf.dm_ack}, 64'd0);
    busIf.dm_req = 1'b0;
    tick();
    tick();
    checkOutput("heldGrantCount", 64'(grantCount - grantsBefore), 64'd1);
    checkOutput("heldBusErr", {63'd0, busIf.bus_err}, 64'd0);

    // Reset in the middle of a store; a late bus_ack must be ignored
    $display("[TB] reset mid-access");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0300, 32'h1234_5678);
    tick();
    checkOutput("rstMidBusReq", {63'd0, busIf.bus_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidBusReqDrop", {63'd0, busIf.bus_req}, 64'd0);
    checkOutput("rstMidBusAddr", {32'd0, busIf.bus_addr}, 64'd0);
    busIf.dm_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'hBAD0_BAD0;
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    tick();
    checkOutput("lateAckDm", {63'd0, busIf.dm_ack}, 64'd0);
    checkOutput("lateAckIf", {63'd0, busIf.if_ack}, 64'd0);
    checkOutput("lateAckBusReq", {63'd0, busIf.bus_req}, 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Fetch with no bus_ack: aborted after four busy cycles
    $display("[TB] timeout");
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sb.push_back('{isData: 1'b0, rdata: 32'h0});
    tick();
    checkOutput("toBusReq", {63'd0, busIf.bus_req}, 64'd1);
    tick();
    tick();
    tick();
    checkOutput("toStillBusy", {63'd0, busIf.bus_req}, 64'd1);
    checkOutput("toNoErrYet", {63'd0, busIf.bus_err}, 64'd0);
    tick();
    checkOutput("toBusErr", {63'd0, busIf.bus_err}, 64'd1);
    checkOutput("toIfAck", {63'd0, busIf.if_ack}, 64'd1);
    checkOutput("toIfRdata", {32'd0, busIf.if_rdata}, 64'd0);
    checkOutput("toBusReqDrop", {63'd0, busIf.bus_req}, 64'd0);
    busIf.if_req = 1'b0;
    tick();
    checkOutput("toErrPulse", {63'd0, busIf.bus_err}, 64'd0);

    // bus_ack in the expiry cycle completes normally
    $display("[TB] timeout race");
    applyStimulus(1'b1, 32'h0000_0044, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sb.push_back('{isData: 1'b0, rdata: 32'h5555_AAAA});
    tick();
    tick();
    tick();
    tick();
    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'h5555_AAAA;
    tick();
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 32'h0;
    checkOutput("raceIfAck", {63'd0, busIf.if_ack}, 64'd1);
    checkOutput("raceIfRdata", {32'd0, busIf.if_rdata}, 64'h5555_AAAA);
    checkOutput("raceBusErr", {63'd0, busIf.bus_err}, 64'd0);
    busIf.if_req = 1'b0;
    tick();
`endif

    tick();
    checkOutput("scoreboardEmpty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
